// File: rtl/sram_pkg.sv
// Shared types and parameter sanity helpers for the parametrised 1RW SRAM model.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sram_pkg;

  // Clear engine states: sweep in progress, or normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_e;

  // Word width must split into a whole number of non-empty write lanes.
  function automatic bit mask_width_ok(input int width, input int mask_w);
    return (mask_w > 0) && (width >= mask_w) && ((width % mask_w) == 0);
  endfunction

  // Only one- and two-stage read pipelines are modelled.
  function automatic bit read_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Address width, never narrower than one bit so a single-word array still has a port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_clear_engine.sv
// Post-reset clear sweep: walks every address once, then parks in READY for good.
// Latency: BUSY stays high for exactly DEPTH rising edges after reset release.
// Backpressure: none; the top drops every access while BUSY is high.
module sram_clear_engine
  import sram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int AW             = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          ce,
  input  logic          rstb,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  sram_state_e   state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  // State and sweep pointer; a reset mid-sweep restarts from address 0.
  always_ff @(posedge ce or negedge rstb) begin
    if (!rstb) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state and sweep outputs: one word cleared per edge, leave after the last word.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy       = 1'b0;
    clr_we     = 1'b0;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  assign clr_addr = clr_addr_q;

endmodule

// File: rtl/sram_1rw_param.sv
// Parametrised single-port SRAM model: lane-masked writes, 1/2-cycle reads, post-reset clear.
// Latency: read data and RVALID appear READ_LATENCY edges after the request edge.
// Backpressure: none; accesses are simply ignored while BUSY (clear sweep) is high.
module sram_1rw_param
  import sram_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 256,
  parameter int               MASK_W         = 8,
  parameter int               READ_LATENCY   = 1,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE     = '0,
  parameter int               AW             = addr_width(DEPTH),
  parameter int               NL             = WIDTH / MASK_W
) (
  input  logic             CE,
  input  logic             RSTB,
  input  logic [AW-1:0]    A,
  input  logic             CSB,
  input  logic             WEB,
  input  logic [NL-1:0]    BWEB,
  input  logic             OEB,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             RVALID,
  output logic             BUSY
);

  // Reject configurations the model cannot represent before any simulation time passes.
  generate
    if (!mask_width_ok(WIDTH, MASK_W)) begin : g_bad_mask
      $fatal(1, "sram_1rw_param: WIDTH must be a non-zero multiple of MASK_W");
    end
    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
      $fatal(1, "sram_1rw_param: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             re, we, a_in_range;
  logic [WIDTH-1:0] rd_word, wr_word;

  logic [WIDTH-1:0] rd1_dat_q, rd1_dat_d, rd2_dat_q, rd2_dat_d;
  logic             rd1_vld_q, rd1_vld_d, rd2_vld_q, rd2_vld_d;
  logic [WIDTH-1:0] out_dat;

  sram_clear_engine #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .ce       (CE),
    .rstb     (RSTB),
    .busy     (BUSY),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign re         = ~CSB &  WEB & ~BUSY;
  assign we         = ~CSB & ~WEB & ~BUSY;
  assign a_in_range = ({1'b0, A} < DEPTH_EXT);

  // Addressed word (zero when out of range) and its lane-merged write image.
  always_comb begin
    rd_word = '0;
    if (a_in_range) begin
      rd_word = mem[A];
    end
    wr_word = rd_word;
    for (int k = 0; k < NL; k++) begin
      if (!BWEB[k]) begin
        wr_word[k*MASK_W +: MASK_W] = I[k*MASK_W +: MASK_W];
      end
    end
  end

  // Array update: the sweep owns the port while running; out-of-range writes vanish.
  always_ff @(posedge CE) begin
    if (RSTB) begin
      if (clr_we) begin
        mem[clr_addr] <= INIT_VALUE;
      end else if (we && a_in_range) begin
        mem[A] <= wr_word;
      end
    end
  end

  // Read pipeline next values: data regs hold between reads, valids pulse per read.
  always_comb begin
    rd1_dat_d = rd1_dat_q;
    rd1_vld_d = re;
    if (re) begin
      rd1_dat_d = rd_word;
    end
    rd2_dat_d = rd2_dat_q;
    rd2_vld_d = rd1_vld_q;
    if (rd1_vld_q) begin
      rd2_dat_d = rd1_dat_q;
    end
  end

  // Read pipeline registers.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      rd1_dat_q <= '0;
      rd1_vld_q <= 1'b0;
      rd2_dat_q <= '0;
      rd2_vld_q <= 1'b0;
    end else begin
      rd1_dat_q <= rd1_dat_d;
      rd1_vld_q <= rd1_vld_d;
      rd2_dat_q <= rd2_dat_d;
      rd2_vld_q <= rd2_vld_d;
    end
  end

  assign out_dat = (READ_LATENCY == 2) ? rd2_dat_q : rd1_dat_q;
  assign RVALID  = (READ_LATENCY == 2) ? rd2_vld_q : rd1_vld_q;
  assign O       = OEB ? {WIDTH{1'bz}} : out_dat;

endmodule

// File: tb/tb_sram_1rw_param.sv
// Directed bench: a 256-word latency-1 instance and a 200-word latency-2 instance share stimulus.
module tb_sram_1rw_param;

  logic        ce = 1'b0;
  logic        rstb = 1'b0;
  logic [7:0]  a = '0;
  logic        csb = 1'b1;
  logic        web = 1'b1;
  logic [3:0]  bweb = 4'hF;
  logic        oeb = 1'b0;
  logic [31:0] din = '0;
  wire  [31:0] o0, o1;
  wire         rv0, rv1, busy0, busy1;

  int n_assert = 0;
  int n_fail   = 0;
  int e0, e1;

  always #5 ce = ~ce;

  sram_1rw_param #(.WIDTH(32), .DEPTH(256), .MASK_W(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u0 (
    .CE(ce), .RSTB(rstb), .A(a), .CSB(csb), .WEB(web), .BWEB(bweb), .OEB(oeb), .I(din),
    .O(o0), .RVALID(rv0), .BUSY(busy0)
  );

  sram_1rw_param #(.WIDTH(32), .DEPTH(200), .MASK_W(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u1 (
    .CE(ce), .RSTB(rstb), .A(a), .CSB(csb), .WEB(web), .BWEB(bweb), .OEB(oeb), .I(din),
    .O(o1), .RVALID(rv1), .BUSY(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access cycle: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic c, input logic w, input logic [7:0] ad,
                     input logic [3:0] bw, input logic oe, input logic [31:0] d);
    @(negedge ce);
    csb = c; web = w; a = ad; bweb = bw; oeb = oe; din = d;
    @(posedge ce);
    #1;
  endtask

  // Release reset and count edges until each instance drops BUSY; optionally poke it mid-sweep.
  task automatic measure(input bit inject, output int b0, output int b1);
    b0 = 0; b1 = 0;
    @(negedge ce);
    rstb = 1'b1; csb = 1'b1; web = 1'b1; bweb = 4'h0; oeb = 1'b0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge ce);
      #1;
      if (inject && e == 252) chk("busy_read_rvalid", {31'b0, rv0}, 32'd0);
      if (!busy0 && b0 == 0) b0 = e;
      if (!busy1 && b1 == 0) b1 = e;
      if (b0 != 0 && b1 != 0) break;
      @(negedge ce);
      csb = 1'b1; web = 1'b1;
      if (inject && e + 1 == 250) begin csb = 1'b0; web = 1'b0; a = 8'd5; din = 32'hFFFF_FFFF; end
      if (inject && e + 1 == 252) begin csb = 1'b0; web = 1'b1; a = 8'd9; end
    end
    @(negedge ce);
    csb = 1'b1; web = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy0", {31'b0, busy0}, 32'd1);
    chk("rst_busy1", {31'b0, busy1}, 32'd1);
    chk("rst_rvalid0", {31'b0, rv0}, 32'd0);
    chk("rst_o0", o0, 32'd0);
    chk("rst_o1", o1, 32'd0);

    // Clear sweep lengths
    measure(1'b0, e0, e1);
    chk("sweep_edges_256", 32'(e0), 32'd256);
    chk("sweep_edges_200", 32'(e1), 32'd200);

    // Every word cleared, one RVALID per back-to-back read
    for (int k = 0; k < 256; k++) begin
      cyc(1'b0, 1'b1, 8'(k), 4'hF, 1'b0, 32'd0);
      chk("clear_read", {rv0, o0[30:0]}, 32'h8000_0000);
    end

    // Lane-masked write, then read
    cyc(1'b0, 1'b0, 8'd5, 4'b1010, 1'b0, 32'hDEAD_BEEF);
    chk("write_no_rvalid", {31'b0, rv0}, 32'd0);
    cyc(1'b0, 1'b1, 8'd5, 4'hF, 1'b0, 32'd0);
    chk("mask_read_o0", o0, 32'h00AD_00EF);
    chk("mask_read_rv0", {31'b0, rv0}, 32'd1);
    cyc(1'b1, 1'b1, 8'd0, 4'hF, 1'b0, 32'd0);
    chk("mask_read_o1", o1, 32'h00AD_00EF);
    chk("mask_read_rv1", {31'b0, rv1}, 32'd1);
    chk("idle_rv0", {31'b0, rv0}, 32'd0);
    chk("idle_hold_o0", o0, 32'h00AD_00EF);

    // All-ones mask write is a no-op
    cyc(1'b0, 1'b0, 8'd5, 4'hF, 1'b0, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 8'd5, 4'hF, 1'b0, 32'd0);
    chk("noop_write", o0, 32'h00AD_00EF);

    // Latency-2 back-to-back reads
    cyc(1'b0, 1'b0, 8'd1, 4'h0, 1'b0, 32'h1111_1111);
    cyc(1'b0, 1'b0, 8'd2, 4'h0, 1'b0, 32'h2222_2222);
    cyc(1'b0, 1'b0, 8'd3, 4'h0, 1'b0, 32'h3333_3333);
    cyc(1'b0, 1'b1, 8'd1, 4'hF, 1'b0, 32'd0);
    chk("l2_edge_n_rv1", {31'b0, rv1}, 32'd0);
    chk("l1_read1", o0, 32'h1111_1111);
    cyc(1'b0, 1'b1, 8'd2, 4'hF, 1'b0, 32'd0);
    chk("l2_read1", {rv1, o1[30:0]}, {1'b1, 31'h1111_1111});
    cyc(1'b0, 1'b1, 8'd3, 4'hF, 1'b0, 32'd0);
    chk("l2_read2", {rv1, o1[30:0]}, {1'b1, 31'h2222_2222});
    cyc(1'b1, 1'b1, 8'd0, 4'hF, 1'b0, 32'd0);
    chk("l2_read3", {rv1, o1[30:0]}, {1'b1, 31'h3333_3333});
    cyc(1'b1, 1'b1, 8'd0, 4'hF, 1'b0, 32'd0);
    chk("l2_after_rv1", {31'b0, rv1}, 32'd0);
    chk("l2_after_hold", o1, 32'h3333_3333);

    // Output enable: high-Z while OEB=1, held data once re-enabled
    cyc(1'b0, 1'b1, 8'd3, 4'hF, 1'b1, 32'd0);
    chk("oeb_rvalid", {31'b0, rv0}, 32'd1);
    n_assert++;
    assert (o0 !== 32'h3333_3333) else begin
      n_fail++;
      $error("FAIL oeb_tristate observed=%h expected=not driven", o0);
    end
    cyc(1'b1, 1'b1, 8'd0, 4'hF, 1'b0, 32'd0);
    chk("oeb_release_o0", o0, 32'h3333_3333);
    chk("oeb_release_rv0", {31'b0, rv0}, 32'd0);

    // Out-of-range on the 200-word instance
    cyc(1'b0, 1'b0, 8'd210, 4'h0, 1'b0, 32'hABCD_1234);
    cyc(1'b0, 1'b1, 8'd210, 4'hF, 1'b0, 32'd0);
    chk("inrange_210_u0", o0, 32'hABCD_1234);
    cyc(1'b1, 1'b1, 8'd0, 4'hF, 1'b0, 32'd0);
    chk("oor_read_o1", o1, 32'd0);
    chk("oor_read_rv1", {31'b0, rv1}, 32'd1);
    cyc(1'b0, 1'b0, 8'd199, 4'h0, 1'b0, 32'h5A5A_1234);
    cyc(1'b0, 1'b1, 8'd199, 4'hF, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 8'd0, 4'hF, 1'b0, 32'd0);
    chk("last_word_o1", {rv1, o1[30:0]}, {1'b1, 31'h5A5A_1234});

    // Reset mid-sweep, then a full restart with accesses ignored while busy
    @(negedge ce);
    rstb = 1'b0;
    @(negedge ce);
    rstb = 1'b1;
    repeat (100) @(posedge ce);
    @(negedge ce);
    rstb = 1'b0;
    #1;
    chk("abort_busy0", {31'b0, busy0}, 32'd1);
    chk("abort_rv0", {31'b0, rv0}, 32'd0);
    measure(1'b1, e0, e1);
    chk("restart_edges_256", 32'(e0), 32'd256);
    chk("restart_edges_200", 32'(e1), 32'd200);
    cyc(1'b0, 1'b1, 8'd5, 4'hF, 1'b0, 32'd0);
    chk("busy_write_dropped", o0, 32'd0);
    chk("busy_write_rv0", {31'b0, rv0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
